// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
//   Shared definitions for the store packer: the request size encodings, the
//   FSM state enumeration and the size-to-lane-mask helper.
//   Optional feature macro: STORE_PACKER_SPLIT_EN. When it is defined, the
//   BEAT1 state exists for stores that cross a word boundary.
// -----------------------------------------------------------------------------
package store_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
`ifdef STORE_PACKER_SPLIT_EN
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
`else
    BEAT0 = 2'b01
`endif
  } state_t;

  // Byte-lane mask of an unshifted store; the reserved size gives no lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001;
      SIZE_H:  mask = 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// -----------------------------------------------------------------------------
// store_lane_gen
//   Combinational lane placement for a store. The right-justified data and
//   its size mask are shifted by the byte offset into an 8-lane (two-word)
//   window; lanes outside the mask are forced to zero.
//   Ports:
//     off       in   2  byte offset within the word
//     size      in   2  size encoding (store_pkg SIZE_*)
//     data      in  32  right-justified store data
//     wide_data out 64  lane-positioned data, [31:0] first word, [63:32] next
//     wide_mask out  8  byte enables for the two-word window
// -----------------------------------------------------------------------------
module store_lane_gen
  import store_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_mask
);

  logic [63:0] shifted_s;

  // Shift data and mask into position, then clear the unused lanes.
  always_comb begin
    wide_mask = {4'b0000, size_mask(size)} << off;
    shifted_s = {32'h0000_0000, data} << {off, 3'b000};
    wide_data = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (wide_mask[i]) begin
        wide_data[8*i +: 8] = shifted_s[8*i +: 8];
      end else begin
        wide_data[8*i +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/store_packer.sv
// -----------------------------------------------------------------------------
// store_packer
//   Converts byte/half/word store requests at arbitrary byte addresses into
//   word-aligned memory write beats with byte enables. A store that spills
//   into the next word is issued as two beats when STORE_PACKER_SPLIT_EN is
//   defined; otherwise it is rejected with an err pulse, as is the reserved
//   size encoding. All outputs are registered.
//   Optional feature macro: STORE_PACKER_SPLIT_EN.
//   Ports:
//     clk        in   1           rising-edge clock
//     rst        in   1           asynchronous active-high reset
//     req_valid  in   1           store request present
//     req_ready  out  1           request accepted when high with req_valid
//     req_addr   in   ADDR_WIDTH  byte address of store
//     req_data   in   32          right-justified store data
//     req_size   in   2           00 byte, 01 half, 10 word, 11 reserved
//     mem_valid  out  1           memory write beat present
//     mem_ready  in   1           memory accepts beat
//     mem_addr   out  ADDR_WIDTH  word-aligned beat address
//     mem_wdata  out  32          lane-positioned write data
//     mem_be     out  4           byte enables
//     err        out  1           one-cycle pulse on rejected request
// -----------------------------------------------------------------------------
module store_packer
  import store_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  err
);

  state_t      state_r;
  logic [63:0] wide_data_s;
  logic [7:0]  wide_mask_s;
  logic        accept_s;
  logic        crossing_s;
  logic        reject_s;

  store_lane_gen u_lane_gen (
    .off       (req_addr[1:0]),
    .size      (req_size),
    .data      (req_data),
    .wide_data (wide_data_s),
    .wide_mask (wide_mask_s)
  );

  assign accept_s   = req_valid && req_ready;
  assign crossing_s = |wide_mask_s[7:4];

`ifdef STORE_PACKER_SPLIT_EN
  // Second-word lanes captured at accept, replayed in BEAT1.
  logic [31:0] hi_data_r;
  logic [3:0]  hi_be_r;

  assign reject_s = (req_size == SIZE_RSV);
`else
  logic        unused_hi_data;

  assign reject_s       = (req_size == SIZE_RSV) || crossing_s;
  assign unused_hi_data = ^wide_data_s[63:32];
`endif

  // Request/beat FSM with all handshake and beat outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      mem_valid <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
`ifdef STORE_PACKER_SPLIT_EN
      hi_data_r <= 32'h0000_0000;
      hi_be_r   <= 4'b0000;
`endif
    end else begin
      err <= 1'b0;
      case (state_r)
        IDLE: begin
          // Also raises req_ready on the first edge after reset release.
          req_ready <= 1'b1;
          if (accept_s) begin
            if (reject_s) begin
              err <= 1'b1;
            end else begin
              state_r   <= BEAT0;
              req_ready <= 1'b0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wide_data_s[31:0];
              mem_be    <= wide_mask_s[3:0];
`ifdef STORE_PACKER_SPLIT_EN
              hi_data_r <= wide_data_s[63:32];
              hi_be_r   <= wide_mask_s[7:4];
`endif
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_PACKER_SPLIT_EN
            if (hi_be_r != 4'b0000) begin
              state_r   <= BEAT1;
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= hi_data_r;
              mem_be    <= hi_be_r;
            end else begin
              state_r   <= IDLE;
              mem_valid <= 1'b0;
              req_ready <= 1'b1;
            end
`else
            state_r   <= IDLE;
            mem_valid <= 1'b0;
            req_ready <= 1'b1;
`endif
          end
        end
`ifdef STORE_PACKER_SPLIT_EN
        BEAT1: begin
          if (mem_ready) begin
            state_r   <= IDLE;
            mem_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state_r   <= IDLE;
          mem_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_packer.sv
// -----------------------------------------------------------------------------
// tb_store_packer
//   Directed vectors for store_packer. Expected beats and err pulses are
//   queued when a request is issued; a monitor on the falling clock edge pops
//   and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_store_packer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        err;

  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  store_packer #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d; e.be = b;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.addr = 32'h0; e.data = 32'h0; e.be = 4'h0;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: req_ready 0, expected 1 within 50 cycles");
    end else begin
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d expected events outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compares handshaken beats, err pulses, stall stability.
  initial begin : monitor
    bit          prev_err;
    bit          hold;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_be;
    exp_t        e;
    prev_err = 1'b0; hold = 1'b0;
    h_addr = 32'h0; h_data = 32'h0; h_be = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_err = 1'b0; hold = 1'b0;
      end else begin
        if (err) begin
          check("err_width", {31'h0, prev_err}, 32'h0);
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_err: err 1, expected no event");
          end else begin
            e = q.pop_front();
            check("event_is_err", {31'h0, e.is_err}, 32'h1);
          end
        end
        prev_err = err;
        if (mem_valid) check("req_ready_busy", {31'h0, req_ready}, 32'h0);
        if (hold) begin
          check("hold_valid", {31'h0, mem_valid}, 32'h1);
          check("hold_addr", mem_addr, h_addr);
          check("hold_wdata", mem_wdata, h_data);
          check("hold_be", {28'h0, mem_be}, {28'h0, h_be});
        end
        if (mem_valid && mem_ready) begin
          hold = 1'b0;
          if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_beat: addr 0x%08h wdata 0x%08h be %b, expected none",
                     mem_addr, mem_wdata, mem_be);
          end else begin
            e = q.pop_front();
            check("event_is_beat", {31'h0, e.is_err}, 32'h0);
            check("beat_addr", mem_addr, e.addr);
            check("beat_wdata", mem_wdata, e.data);
            check("beat_be", {28'h0, mem_be}, {28'h0, e.be});
          end
        end else if (mem_valid) begin
          hold = 1'b1; h_addr = mem_addr; h_data = mem_wdata; h_be = mem_be;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0;
    req_size = 2'b00; mem_ready = 1'b1;

    // Reset state
    #12;
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk); rst = 1'b0;
    check("rel_req_ready_low", {31'h0, req_ready}, 32'h0);
    @(posedge clk); #1;
    check("rel_req_ready_high", {31'h0, req_ready}, 32'h1);

    // Byte at top lane
    push_beat(32'h0000_1000, 32'hAB00_0000, 4'b1000);
    send(32'h0000_1003, 32'h0000_00AB, 2'b00); drain();
    // Half in middle lanes
    push_beat(32'h0000_2000, 32'h0012_3400, 4'b0110);
    send(32'h0000_2001, 32'h0000_1234, 2'b01); drain();
    // Word crossing a word boundary
`ifdef STORE_PACKER_SPLIT_EN
    push_beat(32'h0000_3000, 32'hCCDD_0000, 4'b1100);
    push_beat(32'h0000_3004, 32'h0000_AABB, 4'b0011);
`else
    push_err();
`endif
    send(32'h0000_3002, 32'hAABB_CCDD, 2'b10); drain();

    // Aligned word with memory stalled for 5 cycles
    push_beat(32'h0000_4000, 32'h1122_3344, 4'b1111);
    mem_ready = 1'b0;
    send(32'h0000_4000, 32'h1122_3344, 2'b10);
    repeat (5) begin
      @(negedge clk);
      check("stall_mem_valid", {31'h0, mem_valid}, 32'h1);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    drain();

    // Reserved size
    push_err();
    send(32'h0000_5000, 32'hDEAD_BEEF, 2'b11); drain();
    // Byte with garbage upper bits: unused lanes must be zero
    push_beat(32'h0000_6000, 32'h0000_005A, 4'b0001);
    send(32'h0000_6000, 32'hFFFF_FF5A, 2'b00); drain();
    // Half ending exactly at the word boundary
    push_beat(32'h0000_7000, 32'hCAFE_0000, 4'b1100);
    send(32'h0000_7002, 32'hBEEF_CAFE, 2'b01); drain();
    // Half crossing
`ifdef STORE_PACKER_SPLIT_EN
    push_beat(32'h0000_7000, 32'hFE00_0000, 4'b1000);
    push_beat(32'h0000_7004, 32'h0000_00CA, 4'b0001);
`else
    push_err();
`endif
    send(32'h0000_7003, 32'h0000_CAFE, 2'b01); drain();
    // Word crossing the top of the address space
`ifdef STORE_PACKER_SPLIT_EN
    push_beat(32'hFFFF_FFFC, 32'h0304_0000, 4'b1100);
    push_beat(32'h0000_0000, 32'h0000_0102, 4'b0011);
`else
    push_err();
`endif
    send(32'hFFFF_FFFE, 32'h0102_0304, 2'b10); drain();
    // Byte in lane 1
    push_beat(32'h0000_8000, 32'h0000_7700, 4'b0010);
    send(32'h0000_8001, 32'h0000_0077, 2'b00); drain();

    // Reset during a stalled BEAT0; no beat may follow
    mem_ready = 1'b0;
`ifdef STORE_PACKER_SPLIT_EN
    send(32'h0000_9002, 32'h5566_7788, 2'b10);
`else
    send(32'h0000_9000, 32'h5566_7788, 2'b10);
`endif
    t = 0;
    while (!mem_valid && t < 20) begin
      @(negedge clk); t++;
    end
    check("pre_rst_mem_valid", {31'h0, mem_valid}, 32'h1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("async_rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("async_rst_req_ready", {31'h0, req_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_beat", {31'h0, mem_valid}, 32'h0);
    end

    // Normal operation resumes after reset
    @(posedge clk); #1;
    push_beat(32'h0000_A000, 32'h0000_00C3, 4'b0001);
    send(32'h0000_A000, 32'h0000_00C3, 2'b00); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_packer.md
STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of request and memory address.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, store request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-006 SHALL have port req_addr, input, ADDR_WIDTH, byte address of store.
REQ-007 SHALL have port req_data, input, 32, store data, right-justified.
REQ-008 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port mem_valid, output, 1, memory write beat present.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts beat.
REQ-011 SHALL have port mem_addr, output, ADDR_WIDTH, word-aligned address (bits [1:0] = 0).
REQ-012 SHALL have port mem_wdata, output, 32, lane-positioned write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables, bit i = byte lane i.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on rejected request.

Function
REQ-015 SHALL implement FSM states IDLE, BEAT0, BEAT1; req_ready = (state == IDLE), registered, no combinational path from req_valid.
REQ-016 SHALL, on accept in IDLE, register request; off = req_addr[1:0], mask = 0001/0011/1111 for byte/half/word.
REQ-017 SHALL present BEAT0 the cycle after accept: mem_addr = addr with [1:0] cleared, mem_wdata = data << 8*off, mem_be = (mask << off)[3:0].
REQ-018 SHALL hold mem_valid and all beat fields stable until mem_ready sampled high.
REQ-019 SHALL, when (mask << off)[7:4] == 0, return to IDLE after BEAT0 handshake; req_ready high next cycle.
REQ-020 SHALL treat a crossing request ((mask << off)[7:4] != 0) per REQ-030/REQ-031.
REQ-021 SHALL in BEAT1 drive mem_addr = BEAT0 address + 4 (wrap modulo 2^ADDR_WIDTH), mem_wdata = data >> 8*(4-off), mem_be = (mask << off)[7:4]; IDLE after handshake.
REQ-022 SHALL reject req_size = 11: accept handshake, no memory beat, err pulse next cycle, remain IDLE.
REQ-023 SHALL zero mem_wdata lanes whose mem_be bit is 0.
REQ-024 SHALL drive mem_valid = 0 in IDLE; mem_addr/mem_wdata/mem_be then don't-care but held at last value.
REQ-025 SHALL complete a non-crossing store in 1 + wait cycles minimum (accept to BEAT0 handshake), crossing in 2 + waits.

Reset
REQ-026 SHALL, on rst assertion, immediately enter IDLE, drive mem_valid = 0, err = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0.
REQ-027 SHALL hold req_ready = 0 while rst high, 1 on first clock edge after deassertion.
REQ-028 SHALL abort any in-flight beat on mid-operation reset; no BEAT1 issued afterwards.
REQ-029 SHALL not require a clock for reset to take effect.

Configuration
REQ-030 SHALL, with STORE_PACKER_SPLIT_EN defined, execute crossing stores as BEAT0 then BEAT1.
REQ-031 SHALL, without STORE_PACKER_SPLIT_EN, reject crossing stores like REQ-022: no beat, err pulse; BEAT1 state and logic absent.

Structure
REQ-032 SHALL place size encodings (SIZE_B/H/W), FSM state enum and mask function in shared package store_pkg.
REQ-033 SHALL be a single module; lane shift/mask logic MAY be sub-module store_lane_gen (combinational, off/size/data -> 64-bit data and 8-bit mask).

Verification
REQ-034 SHALL cover: byte, addr 0x1003, data 0x000000AB -> one beat, addr 0x1000, wdata 0xAB000000, be 1000.
REQ-035 SHALL cover: half, addr 0x2001, data 0x1234 -> one beat, addr 0x2000, wdata 0x00123400, be 0110.
REQ-036 SHALL cover (SPLIT_EN): word, addr 0x3002, data 0xAABBCCDD -> beat0 0x3000/0xCCDD0000/1100, beat1 0x3004/0x0000AABB/0011; without macro -> err pulse, no beat.
REQ-037 SHALL cover: mem_ready low 5 cycles on word 0x4000 -> mem_valid and fields stable, req_ready low throughout.
REQ-038 SHALL cover: req_size 11 -> err one cycle, mem_valid never high.
REQ-039 SHALL cover: rst asserted during BEAT0 of crossing store -> mem_valid 0 immediately, no BEAT1, req_ready 1 after release.
